// File: rtl/alu_serial.sv
// alu_serial: multi-cycle, bit-sliced ALU behind a start/busy/done handshake.
// Processes SLICE bits per clock, LSB first, with the carry held in a
// register between slices. Commands: 000 ADD, 001 SUB, 010 XOR, 011 SLT,
// 100 AND, 101 NAND, 110 NOR, 111 OR.
//
// Optional feature: define ALU_SERIAL_ABORT_EN to add an 'abort' input that
// cancels a running operation without a done pulse and without touching
// result/flags.
//
// Handshake: a rising edge with start=1 while not busy (IDLE or DONE)
// accepts the operation and latches operands/command. busy is high for
// exactly WIDTH/SLICE cycles after the accepting edge; then done pulses for
// one cycle and result/flags update on that same edge and hold until the
// next done or reset. start seen while busy is ignored, and busy and done
// are never high together.
module alu_serial #(
  parameter int WIDTH = 32,
  parameter int SLICE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic [2:0]       command,
`ifdef ALU_SERIAL_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             zero,
  output logic             overflow
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [2:0] CMD_ADD  = 3'b000;
  localparam logic [2:0] CMD_SUB  = 3'b001;
  localparam logic [2:0] CMD_XOR  = 3'b010;
  localparam logic [2:0] CMD_SLT  = 3'b011;
  localparam logic [2:0] CMD_AND  = 3'b100;
  localparam logic [2:0] CMD_NAND = 3'b101;
  localparam logic [2:0] CMD_NOR  = 3'b110;
  localparam logic [2:0] CMD_OR   = 3'b111;

  // Reject slice widths that do not tile the operand.
  if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_slice
    $error("alu_serial: WIDTH must be a multiple of SLICE");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Operand shift registers, command, inter-slice carry, slice counter and
  // the partial result that is assembled from the top down.
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       cmd_q, cmd_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  // Architectural outputs, written only on the done edge.
  logic [WIDTH-1:0] result_q, result_d;
  logic             carryout_q, carryout_d;
  logic             zero_q, zero_d;
  logic             overflow_q, overflow_d;

  logic accept;
  logic last_slice;
  logic abort_run;

  assign accept     = start && (state_q != S_RUN);
  assign last_slice = (cnt_q == CW'(NSLICE - 1));

`ifdef ALU_SERIAL_ABORT_EN
  assign abort_run = abort && (state_q == S_RUN);
`else
  assign abort_run = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort takes priority over finishing the last slice.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: begin
        if (abort_run)       state_d = S_IDLE;
        else if (last_slice) state_d = S_DONE;
      end
      S_DONE: state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);

  // Slice arithmetic: ripple through SLICE bits of the current slice.
  logic             is_sub;
  logic             is_arith;
  logic [SLICE-1:0] a_s, b_s, b_eff, sum_s, slice_res;
  logic             c_run, c_msb_in, c_out;

  always_comb begin
    is_sub    = (cmd_q == CMD_SUB) || (cmd_q == CMD_SLT);
    is_arith  = (cmd_q == CMD_ADD) || (cmd_q == CMD_SUB);
    a_s       = a_q[SLICE-1:0];
    b_s       = b_q[SLICE-1:0];
    b_eff     = is_sub ? ~b_s : b_s;
    sum_s     = '0;
    c_run     = carry_q;
    c_msb_in  = carry_q;
    for (int i = 0; i < SLICE; i++) begin
      sum_s[i] = a_s[i] ^ b_eff[i] ^ c_run;
      if (i == SLICE - 1) c_msb_in = c_run;
      c_run = (a_s[i] & b_eff[i]) | (a_s[i] & c_run) | (b_eff[i] & c_run);
    end
    c_out = c_run;

    slice_res = '0;
    case (cmd_q)
      CMD_ADD, CMD_SUB: slice_res = sum_s;
      CMD_XOR:          slice_res = a_s ^ b_s;
      CMD_SLT:          slice_res = '0;
      CMD_AND:          slice_res = a_s & b_s;
      CMD_NAND:         slice_res = ~(a_s & b_s);
      CMD_NOR:          slice_res = ~(a_s | b_s);
      CMD_OR:           slice_res = a_s | b_s;
      default:          slice_res = '0;
    endcase
  end

  // Datapath next-state: latch on accept, shift one slice per RUN cycle,
  // and publish result/flags when the last slice completes.
  logic             ovf_fin;
  logic             less;
  logic [WIDTH-1:0] final_res;

  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    cmd_d      = cmd_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    result_d   = result_q;
    carryout_d = carryout_q;
    zero_d     = zero_q;
    overflow_d = overflow_q;

    // Overflow/sign decode is only meaningful on the last (MSB) slice.
    ovf_fin   = c_msb_in ^ c_out;
    less      = sum_s[SLICE-1] ^ ovf_fin;
    final_res = (acc_q >> SLICE) | (WIDTH'(slice_res) << (WIDTH - SLICE));
    if (cmd_q == CMD_SLT) final_res = WIDTH'(less);

    if (accept) begin
      a_d     = operandA;
      b_d     = operandB;
      cmd_d   = command;
      carry_d = (command == CMD_SUB) || (command == CMD_SLT);
      cnt_d   = '0;
      acc_d   = '0;
    end else if ((state_q == S_RUN) && !abort_run) begin
      a_d     = a_q >> SLICE;
      b_d     = b_q >> SLICE;
      carry_d = c_out;
      cnt_d   = cnt_q + CW'(1);
      acc_d   = (acc_q >> SLICE) | (WIDTH'(slice_res) << (WIDTH - SLICE));
      if (last_slice) begin
        cnt_d      = '0;
        result_d   = final_res;
        carryout_d = is_arith ? c_out : 1'b0;
        overflow_d = is_arith ? ovf_fin : 1'b0;
        zero_d     = (final_res == '0);
      end
    end
  end

  // Datapath registers; reset clears everything including the outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q        <= '0;
      b_q        <= '0;
      cmd_q      <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      carryout_q <= 1'b0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      cmd_q      <= cmd_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      carryout_q <= carryout_d;
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
    end
  end

  assign result   = result_q;
  assign carryout = carryout_q;
  assign zero     = zero_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_alu_serial.sv
// Bench for alu_serial: a WIDTH=32/SLICE=1 instance and a WIDTH=32/SLICE=8
// instance sharing operand/command inputs, each with its own start.
module tb_alu_serial;
  localparam int W = 32;

  localparam logic [2:0] ADD  = 3'b000;
  localparam logic [2:0] SUB  = 3'b001;
  localparam logic [2:0] XOR  = 3'b010;
  localparam logic [2:0] SLT  = 3'b011;
  localparam logic [2:0] AND  = 3'b100;
  localparam logic [2:0] NAND = 3'b101;
  localparam logic [2:0] NOR  = 3'b110;
  localparam logic [2:0] OR   = 3'b111;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic         start, start8;
  logic [W-1:0] opa, opb;
  logic [2:0]   cmd;
  logic         busy, done, cy, zr, ov;
  logic [W-1:0] res;
  logic         busy8, done8, cy8, zr8, ov8;
  logic [W-1:0] res8;

  alu_serial #(.WIDTH(W), .SLICE(1)) u_dut (
    .clk(clk), .reset(reset), .start(start),
    .operandA(opa), .operandB(opb), .command(cmd),
    .busy(busy), .done(done), .result(res),
    .carryout(cy), .zero(zr), .overflow(ov)
  );

  alu_serial #(.WIDTH(W), .SLICE(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8),
    .operandA(opa), .operandB(opb), .command(cmd),
    .busy(busy8), .done(done8), .result(res8),
    .carryout(cy8), .zero(zr8), .overflow(ov8)
  );

  // Scoreboard: {result, carryout, zero, overflow}
  logic [W+2:0] exp_q[$];
  logic [W+2:0] last_exp;
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model of one ALU operation.
  function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] c);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         co, vo;
    s = '0; r = '0; co = 1'b0; vo = 1'b0;
    case (c)
      ADD: begin
        s  = {1'b0, a} + {1'b0, b};
        r  = s[W-1:0];
        co = s[W];
        vo = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      SUB: begin
        s  = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        r  = s[W-1:0];
        co = s[W];
        vo = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      SLT:  r = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      XOR:  r = a ^ b;
      AND:  r = a & b;
      NAND: r = ~(a & b);
      NOR:  r = ~(a | b);
      default: r = a | b;
    endcase
    return {r, co, (r == '0), vo};
  endfunction

  // Driver: present one operation for one accepting edge, push expectation,
  // then scramble the inputs so a DUT that re-samples them gets caught.
  task automatic issue(input bit sel, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] c);
    opa = a; opb = b; cmd = c;
    if (sel) start8 = 1'b1; else start = 1'b1;
    exp_q.push_back(model(a, b, c));
    @(posedge clk); #1;
    start = 1'b0; start8 = 1'b0;
    opa = $urandom; opb = $urandom; cmd = 3'($urandom_range(0, 7));
  endtask

  // Wait for done with a cycle budget; check busy, latency and outputs.
  // poke_at >= 0 raises start for one cycle at that RUN cycle.
  task automatic wait_done(input bit sel, input int lat, input string name, input int poke_at);
    int cnt = 0;
    logic d, b;
    logic [W+2:0] got, exp;
    d = sel ? done8 : done;
    b = sel ? busy8 : busy;
    while (!d && cnt < lat + 8) begin
      n_checks++;
      if (b !== 1'b1) begin
        n_fail++;
        $display("FAIL %s busy cycle %0d: got %b want 1", name, cnt, b);
      end
      if (cnt == poke_at) begin
        if (sel) start8 = 1'b1; else start = 1'b1;
        opa = $urandom; opb = $urandom;
      end
      @(posedge clk); #1;
      start = 1'b0; start8 = 1'b0;
      cnt++;
      d = sel ? done8 : done;
      b = sel ? busy8 : busy;
    end
    exp = exp_q.pop_front();
    last_exp = exp;
    n_checks++;
    if (!d) begin
      n_fail++;
      $display("FAIL %s timeout: no done after %0d cycles, want %0d", name, cnt, lat);
    end else begin
      if (cnt !== lat) begin
        n_fail++;
        $display("FAIL %s latency: got %0d want %0d", name, cnt, lat);
      end
      n_checks++;
      if (b !== 1'b0) begin
        n_fail++;
        $display("FAIL %s busy with done: got %b want 0", name, b);
      end
      n_checks++;
      got = sel ? {res8, cy8, zr8, ov8} : {res, cy, zr, ov};
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s outputs {res,c,z,v}: got %h/%b%b%b want %h/%b%b%b", name,
                 got[W+2:3], got[2], got[1], got[0], exp[W+2:3], exp[2], exp[1], exp[0]);
      end
    end
  endtask

  // One cycle after done: done must drop and outputs must hold.
  task automatic check_idle(input bit sel, input string name);
    logic [W+2:0] got;
    @(posedge clk); #1;
    got = sel ? {res8, cy8, zr8, ov8} : {res, cy, zr, ov};
    n_checks++;
    if ((sel ? done8 : done) !== 1'b0 || (sel ? busy8 : busy) !== 1'b0 || got !== last_exp) begin
      n_fail++;
      $display("FAIL %s idle/hold: done=%b busy=%b out=%h want 0 0 %h", name,
               sel ? done8 : done, sel ? busy8 : busy, got, last_exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, res, cy, zr, ov, busy8, done8, res8, cy8, zr8, ov8} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got %b %b %h %b%b%b / %b %b %h %b%b%b want all 0",
               busy, done, res, cy, zr, ov, busy8, done8, res8, cy8, zr8, ov8);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({busy, done, busy8, done8} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_release: got busy/done %b%b %b%b want 0000", busy, done, busy8, done8);
    end
  endtask

  task automatic test_add();
    issue(0, 32'h0, 32'h0, ADD);                wait_done(0, 32, "add_0_0", -1);
    check_idle(0, "add_0_0");
    issue(0, 32'h7FFF_FFFF, 32'h1, ADD);        wait_done(0, 32, "add_ovf", -1);
    issue(0, 32'hFFFF_FFFF, 32'h1, ADD);        wait_done(0, 32, "add_wrap", -1);
    check_idle(0, "add_wrap");
  endtask

  task automatic test_sub_slt();
    issue(0, 32'd300, 32'd100, SUB);            wait_done(0, 32, "sub_300_100", -1);
    issue(0, 32'hFFFF_FFFF, 32'd1, SLT);        wait_done(0, 32, "slt_neg", -1);
    issue(0, 32'd200, 32'd100, SLT);            wait_done(0, 32, "slt_pos", -1);
    issue(0, 32'h8000_0000, 32'h1, SUB);        wait_done(0, 32, "sub_ovf", -1);
  endtask

  task automatic test_logic();
    issue(0, 32'h11C, 32'h1FF, NAND);           wait_done(0, 32, "nand", -1);
    issue(0, 32'h11C, 32'h1FF, NOR);            wait_done(0, 32, "nor", -1);
    issue(0, 32'h11C, 32'h1FF, XOR);            wait_done(0, 32, "xor", -1);
    issue(0, 32'h11C, 32'h1FF, AND);            wait_done(0, 32, "and", -1);
    issue(0, 32'h11C, 32'h1FF, OR);             wait_done(0, 32, "or", -1);
  endtask

  task automatic test_ignore_start();
    issue(0, 32'd5, 32'd6, ADD);
    wait_done(0, 32, "ignore_start", 5);
    check_idle(0, "ignore_start");
  endtask

  task automatic test_reset_mid_run();
    logic [W+2:0] dropped;
    int seen = 0;
    issue(0, 32'h1234_5678, 32'h1111_1111, ADD);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, res, cy, zr, ov} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_run: got busy=%b done=%b res=%h c/z/v=%b%b%b want all 0",
               busy, done, res, cy, zr, ov);
    end
    dropped = exp_q.pop_front();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL reset_no_done: got %0d done cycles want 0 (dropped %h)", seen, dropped);
    end
  endtask

  task automatic test_back_to_back();
    issue(0, 32'd10, 32'd3, SUB);               wait_done(0, 32, "b2b32_a", -1);
    issue(0, 32'd1, 32'd2, SLT);                wait_done(0, 32, "b2b32_b", -1);
    check_idle(0, "b2b32_b");
  endtask

  task automatic test_slice8();
    issue(1, 32'h0000_FFFF, 32'h1, ADD);        wait_done(1, 4, "s8_add", -1);
    issue(1, 32'hFFFF_FFFF, 32'h1, ADD);        wait_done(1, 4, "s8_b2b_wrap", -1);
    issue(1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, SUB); wait_done(1, 4, "s8_sub", -1);
    issue(1, 32'h8000_0000, 32'h1, SLT);        wait_done(1, 4, "s8_slt", -1);
    check_idle(1, "s8_slt");
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic [2:0]   c;
    for (int i = 0; i < 16; i++) begin
      a = $urandom; b = $urandom; c = 3'($urandom_range(0, 7));
      if (i % 4 == 1) b = ~a;
      if (i % 4 == 2) b = a;
      issue(0, a, b, c);                        wait_done(0, 32, "rand32", -1);
    end
    for (int i = 0; i < 16; i++) begin
      a = $urandom; b = $urandom; c = 3'($urandom_range(0, 7));
      if (i % 4 == 3) a = 32'h8000_0000;
      issue(1, a, b, c);                        wait_done(1, 4, "rand8", -1);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start8 = 1'b0;
    opa = '0; opb = '0; cmd = '0; last_exp = '0;
    test_reset();
    test_add();
    test_sub_slt();
    test_logic();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    test_slice8();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
